// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pipe_stage_reg_pkg : shared pipeline-stage state encoding and DEPTH check
// Revision: 1.0
// ============================================================================
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    function automatic bit depth_is_legal(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pipe_skid_buf : two-entry head/skid store with registered space flag
// Revision: 1.0
// ============================================================================
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 160
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              i_rdy,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_occ,
    output logic              o_space
);

    pipe_state_e       r_state;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic              r_space;

    // r_space tracks "next state is not TWO" so upstream ready never sees m_ready
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_space <= 1'b0;
        end else if (i_rdy) begin
            r_space <= 1'b1;
            if (i_flush) begin
                r_state <= ST_EMPTY;
                r_head  <= '0;
                r_skid  <= '0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (i_push) begin
                            r_state <= ST_ONE;
                            r_head  <= i_data;
                        end
                    end
                    ST_ONE: begin
                        if (i_push && i_pop) begin
                            r_head <= i_data;
                        end else if (i_push) begin
                            r_state <= ST_TWO;
                            r_skid  <= i_data;
                            r_space <= 1'b0;
                        end else if (i_pop) begin
                            r_state <= ST_EMPTY;
                            r_head  <= '0;
                        end
                    end
                    ST_TWO: begin
                        if (i_pop) begin
                            r_state <= ST_ONE;
                            r_head  <= r_skid;
                            r_skid  <= '0;
                        end else begin
                            r_space <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                        r_head  <= '0;
                        r_skid  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_head  = r_head;
    assign o_occ   = r_state;
    assign o_space = r_space;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register, 1 or 2 entries, with flush
// Revision: 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W      = 160,
    parameter int DEPTH       = 2,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              s_valid_in,
    output logic              s_ready_out,
    input  logic [DATA_W-1:0] s_data_in,
    output logic              m_valid_out,
    input  logic              m_ready_in,
    output logic [DATA_W-1:0] m_data_out,
    output logic [1:0]        occ_out
);

    if (!depth_is_legal(DEPTH)) begin : g_depth_err
        $error("pipe_stage_reg: DEPTH must be 1 or 2");
    end

    logic              w_m_valid;
    logic              w_s_ready;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic [1:0]        w_occ;

    assign w_m_valid = rdy_in & (w_occ != 2'd0);
    assign w_push    = s_valid_in & w_s_ready & ~flush_in;
    assign w_pop     = w_m_valid & m_ready_in & ~flush_in;

    if (DEPTH == 2) begin : g_skid
        logic w_space;

        pipe_skid_buf #(
            .DATA_W (DATA_W)
        ) u_skid (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .i_rdy    (rdy_in),
            .i_flush  (flush_in),
            .i_push   (w_push),
            .i_pop    (w_pop),
            .i_data   (s_data_in),
            .o_head   (w_head),
            .o_occ    (w_occ),
            .o_space  (w_space)
        );

        assign w_s_ready = rdy_in & w_space;
    end else begin : g_single
        logic              r_full;
        logic              r_live;
        logic [DATA_W-1:0] r_data;

        // r_live keeps ready low while in reset and until the first enabled edge
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                r_full <= 1'b0;
                r_live <= 1'b0;
                r_data <= '0;
            end else if (rdy_in) begin
                r_live <= 1'b1;
                if (flush_in) begin
                    r_full <= 1'b0;
                    r_data <= '0;
                end else if (w_push) begin
                    r_full <= 1'b1;
                    r_data <= s_data_in;
                end else if (w_pop) begin
                    r_full <= 1'b0;
                    r_data <= '0;
                end
            end
        end

        assign w_head    = r_data;
        assign w_occ     = {1'b0, r_full};
        assign w_s_ready = rdy_in & r_live & (~w_m_valid | m_ready_in);
    end

    if (ZERO_BUBBLE != 0) begin : g_zero_bubble
        assign m_data_out = w_m_valid ? w_head : '0;
    end else begin : g_raw_data
        assign m_data_out = w_head;
    end

    assign s_ready_out = w_s_ready;
    assign m_valid_out = w_m_valid;
    assign occ_out     = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench for DEPTH=1 (index 0) and DEPTH=2 (index 1)
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         rdy   = 1'b1;
    logic         flush = 1'b0;
    logic         s_valid [2];
    logic [W-1:0] s_data  [2];
    logic         m_ready [2];
    logic         s_ready [2];
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    logic [1:0]   occ     [2];

    int total  = 0;
    int bad    = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [W-1:0] q[$];
        logic [W-1:0] e;

        pipe_stage_reg #(
            .DATA_W      (W),
            .DEPTH       (k + 1),
            .ZERO_BUBBLE (1)
        ) u_dut (
            .clk_in      (clk),
            .rst_n_in    (rst_n),
            .rdy_in      (rdy),
            .flush_in    (flush),
            .s_valid_in  (s_valid[k]),
            .s_ready_out (s_ready[k]),
            .s_data_in   (s_data[k]),
            .m_valid_out (m_valid[k]),
            .m_ready_in  (m_ready[k]),
            .m_data_out  (m_data[k]),
            .occ_out     (occ[k])
        );

        // monitor: compare state against the model and pop on each downstream transfer
        always @(negedge clk) begin
            if (rst_n) begin
                chk($sformatf("mon_occ%0d", k), W'(occ[k]), W'(q.size()));
                chk($sformatf("mon_mvalid%0d", k), W'(m_valid[k]), W'(rdy && q.size() != 0));
                if (chk_on) begin
                    if (k == 0)
                        chk("mon_sready0", W'(s_ready[k]), W'(rdy && (q.size() == 0 || m_ready[k])));
                    else
                        chk("mon_sready1", W'(s_ready[k]), W'(rdy && q.size() < 2));
                end
                if (!m_valid[k]) begin
                    chk($sformatf("mon_bubble%0d", k), m_data[k], '0);
                end else if (m_ready[k] && !flush) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mon_dup%0d: got %0h want none at %0t", k, m_data[k], $time);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("mon_order%0d", k), m_data[k], e);
                    end
                end
            end
        end

        // stimulus side: record each accepted payload as the expected response
        always @(negedge clk) begin
            #1;
            if (!rst_n || (rdy && flush))
                q.delete();
            else if (s_valid[k] && s_ready[k])
                q.push_back(s_data[k]);
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_sready", W'(s_ready[k]), 0);
            chk("rst_mvalid", W'(m_valid[k]), 0);
            chk("rst_occ",    W'(occ[k]), 0);
            chk("rst_data",   m_data[k], 0);
        end
        tick;
        rst_n = 1'b1;
        tick;
        @(negedge clk);
        chk("rel_sready0", W'(s_ready[0]), 1);
        chk("rel_sready1", W'(s_ready[1]), 1);
        chk_on = 1'b1;
        tick;

        // stream 11/22/33 with downstream always ready
        m_ready[1] = 1'b1; s_valid[1] = 1'b1; s_data[1] = 'h11; tick;
        s_data[1] = 'h22; @(negedge clk); chk("st_occ", W'(occ[1]), 1); chk("st_d", m_data[1], 'h11); tick;
        s_data[1] = 'h33; @(negedge clk); chk("st_occ", W'(occ[1]), 1); chk("st_d", m_data[1], 'h22); tick;
        s_valid[1] = 1'b0; @(negedge clk); chk("st_occ", W'(occ[1]), 1); chk("st_d", m_data[1], 'h33); tick;
        @(negedge clk); chk("st_empty", W'(occ[1]), 0); tick;

        // backpressure fills both entries, A3 waits
        m_ready[1] = 1'b0; s_valid[1] = 1'b1; s_data[1] = 'hA1; tick;
        s_data[1] = 'hA2; @(negedge clk); chk("bp_occ", W'(occ[1]), 1); chk("bp_sready", W'(s_ready[1]), 1); tick;
        s_data[1] = 'hA3; @(negedge clk); chk("bp_occ", W'(occ[1]), 2); chk("bp_sready", W'(s_ready[1]), 0);
        chk("bp_d", m_data[1], 'hA1); tick;
        @(negedge clk); chk("bp_hold", W'(occ[1]), 2); chk("bp_sready", W'(s_ready[1]), 0); tick;
        m_ready[1] = 1'b1; @(negedge clk); chk("bp_occ", W'(occ[1]), 2); chk("bp_d", m_data[1], 'hA1); tick;
        @(negedge clk); chk("bp_occ", W'(occ[1]), 1); chk("bp_d", m_data[1], 'hA2); chk("bp_sready", W'(s_ready[1]), 1); tick;
        s_valid[1] = 1'b0; @(negedge clk); chk("bp_occ", W'(occ[1]), 1); chk("bp_d", m_data[1], 'hA3); tick;
        @(negedge clk); chk("bp_empty", W'(occ[1]), 0); tick;

        // flush with two held entries and FF offered
        m_ready[1] = 1'b0; s_valid[1] = 1'b1; s_data[1] = 'hB1; tick;
        s_data[1] = 'hB2; tick;
        s_data[1] = 'hFF; flush = 1'b1; @(negedge clk); chk("fl_occ", W'(occ[1]), 2); tick;
        flush = 1'b0; s_valid[1] = 1'b0;
        @(negedge clk); chk("fl_occ0", W'(occ[1]), 0); chk("fl_mvalid", W'(m_valid[1]), 0); chk("fl_data", m_data[1], 0); tick;

        // flush overrides a simultaneous accept and consume
        s_valid[1] = 1'b1; s_data[1] = 'hC1; tick;
        s_data[1] = 'hFF; flush = 1'b1; m_ready[1] = 1'b1;
        @(negedge clk); chk("fo_sready", W'(s_ready[1]), 1); tick;
        flush = 1'b0; s_valid[1] = 1'b0;
        @(negedge clk); chk("fo_occ", W'(occ[1]), 0); chk("fo_mvalid", W'(m_valid[1]), 0); tick;

        // rdy low freezes the stage, even across flush
        m_ready[1] = 1'b0; s_valid[1] = 1'b1; s_data[1] = 'hD5; tick;
        s_valid[1] = 1'b0; m_ready[1] = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            @(negedge clk);
            chk("rdy_mvalid", W'(m_valid[1]), 0);
            chk("rdy_sready", W'(s_ready[1]), 0);
            chk("rdy_occ", W'(occ[1]), 1);
            tick;
        end
        flush = 1'b0; rdy = 1'b1;
        @(negedge clk); chk("rdy_mvalid", W'(m_valid[1]), 1); chk("rdy_d", m_data[1], 'hD5); tick;
        @(negedge clk); chk("rdy_empty", W'(occ[1]), 0); tick;

        // asynchronous reset between edges with two held entries
        m_ready[1] = 1'b0; s_valid[1] = 1'b1; s_data[1] = 'hE1; tick;
        s_data[1] = 'hE2; tick;
        s_valid[1] = 1'b0; #2;
        rst_n = 1'b0; chk_on = 1'b0; #1;
        chk("ar_occ", W'(occ[1]), 0); chk("ar_mvalid", W'(m_valid[1]), 0);
        chk("ar_sready", W'(s_ready[1]), 0); chk("ar_data", m_data[1], 0);
        tick;
        rst_n = 1'b1; tick;
        @(negedge clk); chk("ar_rel_sready", W'(s_ready[1]), 1); chk("ar_rel_occ", W'(occ[1]), 0);
        chk_on = 1'b1; tick;

        // random valid/ready traffic on both depths
        for (int i = 0; i < 10000; i++) begin
            rdy   = ($urandom_range(15) != 0);
            flush = ($urandom_range(63) == 0);
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = ($urandom_range(3) != 0);
                s_data[k]  = $urandom;
                m_ready[k] = ($urandom_range(2) != 0);
            end
            tick;
        end
        rdy = 1'b1; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            m_ready[k] = 1'b1;
        end
        repeat (4) tick;
        @(negedge clk);
        chk("drain_occ0", W'(occ[0]), 0);
        chk("drain_occ1", W'(occ[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, giving the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving storage entries; only 1 and 2 are legal.
REQ-003 The block SHALL have parameter ZERO_BUBBLE, default 1; when 1, m_data_out SHALL be all-zero whenever m_valid_out is 0.
REQ-004 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-006 rdy_in  input  1  global enable; low freezes the block.
REQ-007 flush_in  input  1  branch-mispredict or trap kill of all held entries.
REQ-008 s_valid_in  input  1  upstream has a payload.
REQ-009 s_ready_out  output  1  block accepts a payload this cycle.
REQ-010 s_data_in  input  DATA_W  upstream payload.
REQ-011 m_valid_out  output  1  head entry valid.
REQ-012 m_ready_in  input  1  downstream consumes the head this cycle.
REQ-013 m_data_out  output  DATA_W  head payload.
REQ-014 occ_out  output  2  entries held: 0, 1 or 2.

Function
REQ-015 An upstream transfer SHALL occur on a rising edge where s_valid_in, s_ready_out and rdy_in are 1 and flush_in is 0.
REQ-016 A downstream transfer SHALL occur on a rising edge where m_valid_out and m_ready_in are 1 and flush_in is 0.
REQ-017 Latency from accepted input to m_valid_out SHALL be exactly 1 cycle, with no combinational path from s_data_in to m_data_out.
REQ-018 When DEPTH=1, s_ready_out SHALL equal rdy_in AND (NOT m_valid_out OR m_ready_in), allowing simultaneous consume and refill.
REQ-019 When DEPTH=2, s_ready_out SHALL be driven from a register plus rdy_in only, and SHALL equal rdy_in AND (occ < 2); it SHALL NOT depend combinationally on m_ready_in.
REQ-020 The DEPTH=2 state machine SHALL have states EMPTY, ONE and TWO with these transitions:
- EMPTY + in -> ONE.
- ONE + in + out -> ONE, with the head replaced by the new payload.
- ONE + in only -> TWO, with the payload held in the skid entry.
- ONE + out only -> EMPTY.
- TWO + out -> ONE, with the skid entry promoted to head.
- Any other combination holds the current state.
REQ-021 Entries SHALL leave in strict FIFO order; no payload is duplicated or dropped except by flush.
REQ-022 When flush_in is 1 and rdy_in is 1, the next state SHALL be EMPTY, occ_out SHALL be 0, and the same-cycle s_data_in SHALL be discarded. Flush SHALL override any transfer.
REQ-023 When rdy_in is 0, all state SHALL hold, including across flush_in, and s_ready_out and m_valid_out SHALL both be 0.
REQ-024 occ_out SHALL equal the FSM state encoding: EMPTY=0, ONE=1, TWO=2.
REQ-025 m_valid_out SHALL equal rdy_in AND (occ_out != 0).

Reset
REQ-026 Asserting rst_n_in low SHALL immediately force the state to EMPTY, all payload registers to 0, and the outputs to s_ready_out=0, m_valid_out=0, m_data_out=0 and occ_out=0.
REQ-027 After deassertion, s_ready_out SHALL be 1 at the first edge where rdy_in is 1.
REQ-028 Reset asserted mid-transfer SHALL discard all entries with no partial payload visible afterwards.

Structure
REQ-029 The FSM state encoding and the DEPTH legality check SHALL live in the shared define package alongside the existing pipeline macros.
REQ-030 The DEPTH=2 storage SHALL be a sub-module, pipe_skid_buf; DEPTH=1 SHALL be generated inline without it.
REQ-031 An illegal DEPTH value SHALL cause an elaboration error.

Verification
REQ-032 Reset release then stream: drive payloads 0x11, 0x22, 0x33 on consecutive cycles with m_ready_in=1 -> the same values appear on consecutive cycles one cycle later, and occ_out stays 1.
REQ-033 Backpressure at DEPTH=2: hold m_ready_in=0 while sending 0xA1, 0xA2, 0xA3 -> occ_out goes 1 then 2, s_ready_out drops and 0xA3 stays pending; releasing m_ready_in yields 0xA1, 0xA2, 0xA3 in order.
REQ-034 Flush with occ=2 and s_valid_in=1 carrying 0xFF -> the next cycle shows occ_out=0, m_valid_out=0 and m_data_out=0, and 0xFF is never observed.
REQ-035 rdy_in low for 3 cycles with occ=1 and m_ready_in=1 -> nothing is consumed, m_valid_out is 0, and the head payload is still present when rdy_in returns high.
REQ-036 Asynchronous reset asserted between clock edges with occ=2 -> outputs are 0 before the next edge.
REQ-037 A random valid/ready scoreboard run of 10k cycles for DEPTH=1 and DEPTH=2 -> zero order, loss or duplication errors.
